// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver: strobed bytes in, valid/ready out, sticky overrun flag.
// Define UART_RX_FIFO_OVERRUN_CNT_EN to build the saturating dropped-byte counter on overrun_cnt_o.
module uart_rx_fifo #(
    parameter int Depth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rx_stb_i,
    input  logic [7:0]               rx_data_i,
    output logic [7:0]               data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(Depth):0]   level_o,
    output logic                     overrun_o,
    input  logic                     overrun_clr_i,
    output logic [7:0]               overrun_cnt_o
);
    localparam int AW = $clog2(Depth);
    localparam int PW = AW + 1;

    logic [Depth-1:0][7:0] mem;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic                  full, push, pop, drop;
    logic                  overrun_q;

    // Extra pointer bit separates full from empty; the difference is the fill level.
    assign level_o = wr_ptr - rd_ptr;
    assign valid_o = (level_o != '0);
    assign full    = (level_o == PW'(Depth));
    assign pop     = valid_o && ready_i;
    assign push    = rx_stb_i && (!full || pop);
    assign drop    = rx_stb_i && full && !pop;
    assign data_o  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; valid_o masks stale contents.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= rx_data_i;
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)              overrun_q <= 1'b0;
        else if (drop)          overrun_q <= 1'b1;
        else if (overrun_clr_i) overrun_q <= 1'b0;
    end
    assign overrun_o = overrun_q;

`ifdef UART_RX_FIFO_OVERRUN_CNT_EN
    logic [7:0] cnt_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                        cnt_q <= '0;
        else if (overrun_clr_i)           cnt_q <= drop ? 8'd1 : 8'd0;
        else if (drop && cnt_q != 8'hFF)  cnt_q <= cnt_q + 8'd1;
    end
    assign overrun_cnt_o = cnt_q;
`else
    assign overrun_cnt_o = '0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: stimulus queues expected bytes, a monitor checks every pop.
module tb_uart_rx_fifo;
    localparam int Depth = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        rx_stb_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [$clog2(Depth):0] level_o;
    logic        overrun_o;
    logic        overrun_clr_i = 1'b0;
    logic [7:0]  overrun_cnt_o;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

`ifdef UART_RX_FIFO_OVERRUN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    uart_rx_fifo #(.Depth(Depth)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .rx_stb_i(rx_stb_i), .rx_data_i(rx_data_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .level_o(level_o),
        .overrun_o(overrun_o), .overrun_clr_i(overrun_clr_i), .overrun_cnt_o(overrun_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic strobe(input logic [7:0] b, input bit accepted);
        rx_stb_i  = 1'b1;
        rx_data_i = b;
        if (accepted) exp_q.push_back(b);
        tick();
        rx_stb_i  = 1'b0;
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < Depth; i++) strobe(base + 8'(i), 1'b1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        ready_i = 1'b1;
        while (valid_o && n < 4 * Depth) begin
            tick();
            n++;
        end
        ready_i = 1'b0;
        chk({name, "_valid_after_drain"}, 32'(valid_o), 32'd0);
        chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: a pop happens at the next edge whenever valid_o && ready_i mid-cycle.
    always @(negedge clk_i) begin
        if (!rst_i && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got %0h want none", data_o);
            end else begin
                chk("pop_data", 32'(data_o), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_overrun", 32'(overrun_o), 32'd0);
        chk("rst_cnt", 32'(overrun_cnt_o), 32'd0);
        tick();
        rst_i = 1'b0;
        tick();

        // Single byte, one-cycle latency, then one pop
        strobe(8'hA5, 1'b1);
        chk("one_valid", 32'(valid_o), 32'd1);
        chk("one_level", 32'(level_o), 32'd1);
        chk("one_data", 32'(data_o), 32'hA5);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("one_pop_valid", 32'(valid_o), 32'd0);
        chk("one_pop_level", 32'(level_o), 32'd0);

        // Fill and drain in order
        fill(8'h00);
        chk("fill_level", 32'(level_o), 32'd16);
        chk("fill_head", 32'(data_o), 32'h00);
        drain("fill");
        chk("fill_level0", 32'(level_o), 32'd0);

        // Drops while full: flag and count, data unchanged
        fill(8'h00);
        strobe(8'h55, 1'b0);
        chk("drop_level", 32'(level_o), 32'd16);
        chk("drop_overrun", 32'(overrun_o), 32'd1);
        chk("drop_cnt", 32'(overrun_cnt_o), CNT_EN ? 32'd1 : 32'd0);
        strobe(8'h56, 1'b0);
        chk("drop2_cnt", 32'(overrun_cnt_o), CNT_EN ? 32'd2 : 32'd0);

        // Clear together with a drop: set wins, count restarts at 1
        overrun_clr_i = 1'b1;
        strobe(8'h66, 1'b0);
        overrun_clr_i = 1'b0;
        chk("clrdrop_overrun", 32'(overrun_o), 32'd1);
        chk("clrdrop_cnt", 32'(overrun_cnt_o), CNT_EN ? 32'd1 : 32'd0);
        overrun_clr_i = 1'b1;
        tick();
        overrun_clr_i = 1'b0;
        chk("clr_overrun", 32'(overrun_o), 32'd0);
        chk("clr_cnt", 32'(overrun_cnt_o), 32'd0);

        // Full with simultaneous pop: strobe accepted, level holds
        ready_i = 1'b1;
        strobe(8'h77, 1'b1);
        ready_i = 1'b0;
        chk("fullpp_level", 32'(level_o), 32'd16);
        chk("fullpp_overrun", 32'(overrun_o), 32'd0);
        chk("fullpp_head", 32'(data_o), 32'h01);
        drain("fullpp");

        // Level 1 with simultaneous push and pop: head replaced
        strobe(8'h11, 1'b1);
        ready_i = 1'b1;
        strobe(8'h22, 1'b1);
        ready_i = 1'b0;
        chk("lvl1_valid", 32'(valid_o), 32'd1);
        chk("lvl1_level", 32'(level_o), 32'd1);
        chk("lvl1_data", 32'(data_o), 32'h22);
        drain("lvl1");

        // Asynchronous reset mid-operation at level 5 with overrun set
        fill(8'h20);
        strobe(8'hEE, 1'b0);
        ready_i = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        ready_i = 1'b0;
        chk("pre_rst_level", 32'(level_o), 32'd5);
        chk("pre_rst_overrun", 32'(overrun_o), 32'd1);
        #2;
        rst_i = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_valid", 32'(valid_o), 32'd0);
        chk("arst_level", 32'(level_o), 32'd0);
        chk("arst_overrun", 32'(overrun_o), 32'd0);
        chk("arst_cnt", 32'(overrun_cnt_o), 32'd0);
        tick();
        rst_i = 1'b0;
        tick();
        strobe(8'h3C, 1'b1);
        chk("post_rst_level", 32'(level_o), 32'd1);
        chk("post_rst_data", 32'(data_o), 32'h3C);
        drain("post_rst");

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
